// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encoding for the serial block.
// Imported by the TX arbiter, its interface and its selector.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int MAX_BURST_DEF     = 16;
  localparam int STALL_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-requester byte stream bundle.
// master = requester side, slave = arbiter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// First set request at or above i_ptr, wrapping to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int PW      = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one
// async_transmitter between NUM_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int MAX_BURST     = MAX_BURST_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   req,
  output logic [NUM_REQ-1:0] grant,
  output logic               tx_start,
  output logic [BYTE_W-1:0]  tx_data,
  input  logic               tx_busy,
  output logic               active
);

  localparam int PW = ptr_w(NUM_REQ);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_SEND      = SEND;
  localparam logic [1:0] ST_WAIT_BUSY = WAIT_BUSY;
  localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0]   STALL_MAX = 16'(STALL_TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PW-1:0]      r_gidx;
  logic [PW-1:0]      r_rr_ptr;
  logic               r_tx_start;
  logic [BYTE_W-1:0]  r_tx_data;
  logic               r_last;
  logic [7:0]         r_burst_cnt;
  logic [15:0]        r_stall_cnt;

  logic [NUM_REQ-1:0] w_win;
  logic [PW-1:0]      w_win_idx;
  logic               w_any;
  logic               w_valid;
  logic               w_last;
  logic [BYTE_W-1:0]  w_data;
  logic               w_hs;
  logic [15:0]        w_stall_nxt;
  logic               w_stall_hit;
  logic               w_pkt_end;
  logic [PW-1:0]      w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (req.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_valid = req.req_valid[r_gidx];
  assign w_last  = req.req_last[r_gidx];
  assign w_data  = req.req_data[BYTE_W*r_gidx +: BYTE_W];

  // A byte is only taken when the transmitter is idle.
  assign w_hs = (r_state == ST_SEND) && !tx_busy && w_valid;

  assign w_stall_nxt = (r_stall_cnt >= STALL_MAX) ?
                       STALL_MAX : r_stall_cnt + 16'd1;
  assign w_stall_hit = (w_stall_nxt == STALL_MAX);

  assign w_pkt_end  = r_last || (r_burst_cnt == BURST_MAX);
  assign w_next_ptr = (r_gidx == LAST_IDX) ?
                      '0 : r_gidx + 1'b1;

  assign req.req_ready = w_hs ? r_grant : '0;

  assign grant    = r_grant;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign active   = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_tx_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_win;
            r_gidx      <= w_win_idx;
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_tx_data   <= w_data;
            r_last      <= w_last;
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_stall_cnt <= '0;
            r_tx_start  <= 1'b1;
            r_state     <= ST_WAIT_BUSY;
          end else if (!w_valid) begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_hit) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_IDLE;
            end
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (w_pkt_end) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a 10-cycle busy
// transmitter model and three scripted byte-stream requesters.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] grant;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       active;

  int n_chk  = 0;
  int n_fail = 0;

  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  int   viol       = 0;
  int   ng_ready   = 0;

  logic [7:0] log_d[$];
  logic [2:0] log_g[$];

  logic [7:0] mem [3][32];
  int   len[3]   = '{0, 0, 0};
  int   cap[3]   = '{0, 0, 0};
  int   start[3] = '{0, 0, 0};
  int   taken[3] = '{0, 0, 0};
  logic [2:0] en = 3'b111;

  uart_tx_arbiter_if #(.NUM_REQ(3)) rif ();

  uart_tx_arbiter #(
    .NUM_REQ       (3),
    .MAX_BURST     (16),
    .STALL_TIMEOUT (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rif),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .active   (active)
  );

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start) busy_cnt <= 10;
  end

  for (genvar i = 0; i < 3; i++) begin : g_req
    int k;
    assign k = taken[i] - start[i];
    assign rif.req_valid[i] = en[i] && (k < len[i]) && (k < cap[i]);
    assign rif.req_data[8*i +: 8] = mem[i][k[4:0]];
    assign rif.req_last[i] = (k == len[i] - 1);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rif.req_ready[i]) taken[i] <= taken[i] + 1;
  end

  always @(negedge clk) begin
    if (tx_start) begin
      log_d.push_back(tx_data);
      log_g.push_back(grant);
      if (tx_busy) viol++;
    end
    if ((rif.req_ready & ~grant) != 3'b000) ng_ready++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] b0, input int n);
    for (int j = 0; j < n; j++) mem[i][j] = b0 + 8'(j);
    len[i]   = n;
    cap[i]   = n;
    start[i] = taken[i];
  endtask

  task automatic wait_log(input string tag, input int n);
    int c;
    c = 0;
    while ((log_d.size() < n || active) && c < 3000) begin
      tick();
      c++;
    end
    chk(tag, 32'(log_d.size() >= n && !active), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int   n0;
    int   c;
    logic seen_s;
    logic seen_r;

    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_grant", grant, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_active", active, 0);
    chk("rst_ready", rif.req_ready, 0);
    chk("rst_ptr", dut.r_rr_ptr, 0);
    rst_n = 1'b1;
    tick();

    // single requester, 3-byte packet, latency checks
    n0 = log_d.size();
    load(0, 8'h41, 3);
    tick();
    chk("t1_grant", grant, 3'b001);
    chk("t1_ready", rif.req_ready, 3'b001);
    chk("t1_nostart", tx_start, 0);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data0", tx_data, 8'h41);
    tick();
    chk("t1_pulse", tx_start, 0);
    wait_log("t1_done", n0 + 3);
    for (int j = 0; j < 3; j++) begin
      chk("t1_d", log_d[n0+j], 8'h41 + 8'(j));
      chk("t1_g", log_g[n0+j], 3'b001);
    end
    chk("t1_rel", grant, 0);
    chk("t1_ptr", dut.r_rr_ptr, 1);

    // simultaneous requests after reset
    rst_n = 1'b0;
    tick();
    tick();
    chk("t2_rst_ptr", dut.r_rr_ptr, 0);
    rst_n = 1'b1;
    tick();
    n0 = log_d.size();
    load(0, 8'hA0, 1);
    load(1, 8'hB1, 1);
    load(2, 8'hC2, 1);
    wait_log("t2_done", n0 + 3);
    for (int j = 0; j < 3; j++) begin
      chk("t2_d", log_d[n0+j], 8'hA0 + 8'h11 * 8'(j));
      chk("t2_g", log_g[n0+j], 3'b001 << j);
    end
    chk("t2_ptr", dut.r_rr_ptr, 0);

    // burst limit: 20-byte packet split by req 2
    n0 = log_d.size();
    load(1, 8'h10, 20);
    load(2, 8'hD0, 1);
    wait_log("t3_done", n0 + 21);
    for (int j = 0; j < 21; j++) begin
      if (j < 16) begin
        chk("t3_d", log_d[n0+j], 8'h10 + 8'(j));
        chk("t3_g", log_g[n0+j], 3'b010);
      end else if (j == 16) begin
        chk("t3_d", log_d[n0+j], 8'hD0);
        chk("t3_g", log_g[n0+j], 3'b100);
      end else begin
        chk("t3_d", log_d[n0+j], 8'h10 + 8'(j - 1));
        chk("t3_g", log_g[n0+j], 3'b010);
      end
    end
    chk("t3_ptr", dut.r_rr_ptr, 2);

    // stall timeout after one byte
    n0 = log_d.size();
    load(0, 8'h55, 3);
    cap[0] = 1;
    load(1, 8'h99, 1);
    c = 0;
    while (log_d.size() == n0 && c < 100) begin tick(); c++; end
    while (!tx_busy && c < 120) begin tick(); c++; end
    while (tx_busy && c < 160) begin tick(); c++; end
    chk("t4_sync", 32'(c < 160), 1);
    repeat (64) tick();
    chk("t4_hold", grant, 3'b001);
    tick();
    chk("t4_release", grant, 0);
    tick();
    chk("t4_next", grant, 3'b010);
    wait_log("t4_done", n0 + 2);
    chk("t4_d0", log_d[n0], 8'h55);
    chk("t4_g0", log_g[n0], 3'b001);
    chk("t4_d1", log_d[n0+1], 8'h99);
    chk("t4_g1", log_g[n0+1], 3'b010);
    chk("t4_taken", taken[0] - start[0], 1);

    // transmitter held busy during SEND
    n0 = log_d.size();
    force_busy = 1'b1;
    load(2, 8'hE7, 1);
    tick();
    chk("t5_grant", grant, 3'b100);
    seen_s = 1'b0;
    seen_r = 1'b0;
    repeat (8) begin
      tick();
      seen_s |= tx_start;
      seen_r |= |rif.req_ready;
    end
    chk("t5_nostart", seen_s, 0);
    chk("t5_noready", seen_r, 0);
    force_busy = 1'b0;
    #1;
    chk("t5_ready", rif.req_ready, 3'b100);
    tick();
    chk("t5_start", tx_start, 1);
    chk("t5_data", tx_data, 8'hE7);
    wait_log("t5_done", n0 + 1);
    chk("t5_ptr", dut.r_rr_ptr, 0);

    // reset during WAIT_DONE
    n0 = log_d.size();
    load(0, 8'h61, 2);
    c = 0;
    while (log_d.size() == n0 && c < 100) begin tick(); c++; end
    repeat (4) tick();
    chk("t6_busy", tx_busy, 1);
    rst_n = 1'b0;
    en[0] = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_start", tx_start, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_active", active, 0);
    chk("t6_ready", rif.req_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_idle", active, 0);
    en[0] = 1'b1;
    seen_s = 1'b0;
    c = 0;
    while (tx_busy && c < 40) begin
      tick();
      c++;
      if (tx_busy) seen_s |= tx_start;
    end
    chk("t6_quiet", seen_s, 0);
    wait_log("t6_done", n0 + 2);
    chk("t6_d1", log_d[n0+1], 8'h62);
    chk("t6_g1", log_g[n0+1], 3'b001);
    chk("t6_ptr", dut.r_rr_ptr, 1);

    chk("start_in_busy", viol, 0);
    chk("ready_nongrant", ng_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single async_transmitter byte channel between NUM_REQ requesters, e.g. game-state reporter, debug echo and GPIO mirror.
- Arbitration is round-robin at packet granularity. A grant is held until the requester's last byte has been sent, MAX_BURST bytes have been sent, or the requester stalls for longer than STALL_TIMEOUT cycles.
- Drives the transmitter's TxD_start/TxD_data and monitors TxD_busy.
- Sits between the requester logic and async_transmitter in the top-level serial block.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before a forced release (1..255).
- STALL_TIMEOUT, 64, cycles the granted requester may hold valid low mid-packet before the grant is released (1..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the current byte as the final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted (combinational, one-hot or zero).
- grant  out  NUM_REQ  registered one-hot owner of the channel; zero when idle.
- tx_start  out  1  one-cycle start pulse to async_transmitter TxD_start.
- tx_data  out  8  byte to async_transmitter TxD_data; stable from the tx_start pulse until tx_busy falls.
- tx_busy  in  1  async_transmitter TxD_busy; rises the cycle after tx_start.
- active  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, grant=0, tx_start=0, tx_data=8'h00, rr_ptr=0, burst_cnt=0, stall_cnt=0. req_ready is combinational and 0 in reset.
- Reset asserted mid-byte: all state clears immediately. The byte already launched inside the transmitter completes on the line regardless. The arbiter re-enters IDLE and waits for tx_busy low before issuing any tx_start.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning upward from rr_ptr with wrap-around.
  - Next cycle: grant = winner (one-hot), burst_cnt = 0, stall_cnt = 0, state = SEND.
  - With no valid, the arbiter stays in IDLE.
- SEND, byte handshake:
  - Handshake fires when tx_busy==0 and req_valid[g]==1.
  - That same cycle: req_ready[g]=1, tx_data is registered from req_data[g], req_last[g] is registered as last_q, burst_cnt increments.
  - Next cycle: tx_start=1 for exactly one cycle; state = WAIT_BUSY.
- SEND, stall:
  - If req_valid[g]==0, stall_cnt increments.
  - When stall_cnt reaches STALL_TIMEOUT: release to IDLE, grant=0, rr_ptr = g+1 mod NUM_REQ.
  - stall_cnt clears on every handshake.
- WAIT_BUSY: wait for tx_busy==1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy==0.
  - Then, if last_q==1 or burst_cnt==MAX_BURST: go to IDLE, grant=0, rr_ptr = g+1 mod NUM_REQ.
  - Otherwise return to SEND.
- Latency:
  - valid in IDLE → grant one cycle later.
  - First handshake in the SEND entry cycle, provided tx_busy is low.
  - tx_start one cycle after the handshake.
- Minimum inter-byte gap: transmitter byte time + 3 cycles.
- Rules:
  - Never more than one tx_start while tx_busy is high or before WAIT_DONE completes.
  - req_ready of non-granted requesters is always 0.
  - Requesters changing req_valid while not granted have no effect until the next IDLE arbitration.
  - A requester dropping valid mid-packet keeps the grant until timeout.
- burst_cnt is 8 bits; stall_cnt is 16 bits and saturates at STALL_TIMEOUT.
- Simultaneous requests in IDLE: only the rr_ptr ordering decides; the lowest index wins after reset.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
  - BYTE_W=8 constant.
  - Default MAX_BURST and STALL_TIMEOUT constants.
- One sub-module rr_pick (NUM_REQ): a combinational round-robin priority selector that takes req vector and pointer and returns one-hot winner plus index. Reused by future arbiters.

Test Plan:
- Single requester 0 sends 3-byte packet 8'h41, 8'h42, 8'h43 (last on the third) against a transmitter model with busy for 10 cycles:
  - three tx_start pulses with tx_data 41, 42, 43 in order;
  - grant=001 throughout, then 000;
  - rr_ptr=1 after release.
- All three requesters valid at once after reset, each with 1-byte packets 8'hA0, 8'hB1, 8'hC2:
  - grant order 001, 010, 100;
  - tx_data order A0, B1, C2.
- Requester 1 sends a 20-byte packet with MAX_BURST=16 while requester 2 is waiting:
  - 16 bytes sent, then grant moves to requester 2;
  - requester 1 resumes with byte 17 on a later grant.
- Granted requester drops valid after byte 1 with STALL_TIMEOUT=64:
  - grant released exactly 64 cycles into the stall;
  - no further tx_start;
  - the next valid requester is granted.
- Hold tx_busy high externally during SEND:
  - no handshake and no tx_start until busy falls;
  - req_ready stays 0.
- Assert rst_n low during WAIT_DONE:
  - all outputs return to reset values asynchronously;
  - after release, no tx_start until tx_busy is low and a request arrives.
